// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART.
//   tx_state_e  : transmitter FSM states
//   PAR_EVEN/ODD: parity selector values
//   parity_calc : parity bit over up to MAX_DATA_BITS data bits (zero-extend narrower words)
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  localparam int MAX_DATA_BITS = 9;

  // Zero padding does not change the XOR, so narrower words can be extended freely.
  function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer.
//   clk, Tx_rst : clock, async active-high reset
//   en          : count while high; counter is held at 0 while low
//   tick        : high in the last cycle of each CLK_PER_BIT-cycle bit period
module uart_baud_tick #(
  parameter int CLK_PER_BIT = 31
) (
  input  logic clk,
  input  logic Tx_rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge Tx_rst) begin
    if (Tx_rst)               cnt_q <= '0;
    else if (!en)             cnt_q <= '0;
    else if (cnt_q == CNT_LAST) cnt_q <= '0;
    else                      cnt_q <= cnt_q + 1'b1;
  end

  assign tick = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready handshake.
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1).
//   clk, Tx_rst : clock, async active-high reset
//   tx_valid    : host offers tx_data
//   tx_data     : word, captured on tx_valid && tx_ready
//   tx_ready    : idle, can accept a word
//   tx_line     : serial output, idle high
//   tx_busy     : frame in progress
//   tx_done     : one-cycle pulse on the edge that ends the frame
// All outputs come straight from flops.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 31,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 Tx_rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_line,
  output logic                 tx_busy,
  output logic                 tx_done
);

  if (CLK_PER_BIT < 2 || CLK_PER_BIT > 2047) begin : g_bad_cpb
    $error("uart_tx_param: CLK_PER_BIT must be 2..2047");
  end
  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_db
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY_EN < 0 || PARITY_EN > 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
    $error("uart_tx_param: PARITY_EN/PARITY_ODD must be 0 or 1");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  // bit index also counts stop bits, which never exceed the data count
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic PAR_SEL = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  tx_state_e            state_q, state_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic [IDX_W-1:0]     idx_q, idx_n;
  logic                 par_q, par_n;
  logic                 line_n, ready_n, busy_n, done_n;
  logic                 tick;

  uart_baud_tick #(.CLK_PER_BIT(CLK_PER_BIT)) u_baud (
    .clk    (clk),
    .Tx_rst (Tx_rst),
    .en     (state_q != IDLE),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge Tx_rst) begin
    if (Tx_rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      par_q    <= 1'b0;
      tx_line  <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state_q  <= state_n;
      shift_q  <= shift_n;
      idx_q    <= idx_n;
      par_q    <= par_n;
      tx_line  <= line_n;
      tx_ready <= ready_n;
      tx_busy  <= busy_n;
      tx_done  <= done_n;
    end
  end

  always_comb begin
    state_n = state_q;
    shift_n = shift_q;
    idx_n   = idx_q;
    par_n   = par_q;
    line_n  = tx_line;
    ready_n = tx_ready;
    busy_n  = tx_busy;
    done_n  = 1'b0;
    case (state_q)
      IDLE: begin
        line_n  = 1'b1;
        ready_n = 1'b1;
        busy_n  = 1'b0;
        idx_n   = '0;
        if (tx_valid && tx_ready) begin
          state_n = START;
          shift_n = tx_data;
          // parity taken from the accepted word, before shifting destroys it
          par_n   = parity_calc(MAX_DATA_BITS'(tx_data), PAR_SEL);
          line_n  = 1'b0;
          ready_n = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          idx_n   = '0;
          line_n  = shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          shift_n = shift_q >> 1;
          if (idx_q == DATA_LAST) begin
            idx_n = '0;
            if (PARITY_EN != 0) begin
              state_n = PARITY;
              line_n  = par_q;
            end else begin
              state_n = STOP;
              line_n  = 1'b1;
            end
          end else begin
            idx_n  = idx_q + 1'b1;
            line_n = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_n = STOP;
          idx_n   = '0;
          line_n  = 1'b1;
        end
      end
      STOP: begin
        line_n = 1'b1;
        if (tick) begin
          if (idx_q == STOP_LAST) begin
            state_n = IDLE;
            idx_n   = '0;
            done_n  = 1'b1;
            ready_n = 1'b1;
            busy_n  = 1'b0;
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        line_n  = 1'b1;
        ready_n = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule
